// File: rtl/riscv_pkg.sv
// Shared core definitions used by the write-back port arbiter.
//   XLEN                    : architectural register width
//   WBARB_STARVE_LIMIT_DEF  : default blocked-cycle budget before a bubble request
//   wbarb_state_e           : arbiter starvation FSM states
package riscv_pkg;

  localparam int unsigned XLEN                   = 32;
  localparam int unsigned WBARB_STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    WBARB_IDLE  = 2'd0,
    WBARB_WAIT  = 2'd1,
    WBARB_FORCE = 2'd2
  } wbarb_state_e;

endpackage

// File: rtl/wb_result_fifo.sv
// Small FIFO holding long-latency-unit results ({rd, data}) awaiting the
// register-file write port.
//   clk, rst_n            : clock, asynchronous active-low reset (discards contents)
//   push, push_rd/data    : enqueue (ignored when full)
//   pop                   : dequeue head (ignored when empty)
//   head_rd, head_data    : oldest entry
//   full, empty, count    : occupancy, count in 0..DEPTH
//   entry_valid, entry_rd : per-slot valid bit and destination, for hazard masks
module wb_result_fifo
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned DW    = XLEN
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [4:0]                 push_rd,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [4:0]                 head_rd,
  output logic [DW-1:0]              head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [DEPTH-1:0]           entry_valid,
  output logic [DEPTH*5-1:0]         entry_rd
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [4:0]    rd_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_rd   = rd_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Pointers are PW bits wide, so DEPTH being a power of two makes them wrap for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      entry_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) rd_mem[i] <= '0;
    end else begin
      if (do_push) begin
        rd_mem[wr_ptr] <= push_rd;
        wr_ptr         <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (do_push && (wr_ptr == PW'(i)))      entry_valid[i] <= 1'b1;
        else if (do_pop && (rd_ptr == PW'(i)))  entry_valid[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) data_mem[wr_ptr] <= push_data;
  end

  always_comb begin
    entry_rd = '0;
    for (int unsigned i = 0; i < DEPTH; i++) entry_rd[i*5 +: 5] = rd_mem[i];
  end

endmodule

// File: rtl/rf_wport_arbiter.sv
// Shares the single register-file write port between the write-back stage
// (always wins) and the long-latency unit, whose results are queued in a FIFO.
// A starvation FSM requests a WB bubble once the queue head has been blocked
// for STARVE_LIMIT consecutive cycles.
//   pipe_wen/waddr/wdata : WB-stage write request
//   lu_valid/ready/rd/data : LU result handshake
//   stall_req            : bubble request to the hazard unit
//   pending_mask         : bit r set while a queued result targets xr
//   rf_wen/waddr/wdata   : register-file write port
module rf_wport_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = WBARB_STARVE_LIMIT_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pipe_wen,
  input  logic [4:0]      pipe_waddr,
  input  logic [XLEN-1:0] pipe_wdata,
  input  logic            lu_valid,
  output logic            lu_ready,
  input  logic [4:0]      lu_rd,
  input  logic [XLEN-1:0] lu_data,
  output logic            stall_req,
  output logic [31:0]     pending_mask,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT) + 1;

  logic [4:0]       head_rd;
  logic [XLEN-1:0]  head_data;
  logic             full, empty;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH*5-1:0] entry_rd;

  logic push, pop, blocked;
  wbarb_state_e state, state_nxt;
  logic [SW-1:0] starve_cnt, cnt_nxt, cnt_inc;

  // x0 results complete the handshake but are never queued.
  assign lu_ready = !full;
  assign push     = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign pop      = !pipe_wen && !empty;
  assign blocked  = pipe_wen && !empty;

  wb_result_fifo #(.DEPTH(DEPTH), .DW(XLEN)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push        (push),
    .push_rd     (lu_rd),
    .push_data   (lu_data),
    .pop         (pop),
    .head_rd     (head_rd),
    .head_data   (head_data),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .entry_valid (entry_valid),
    .entry_rd    (entry_rd)
  );

  // Reset gating keeps the port quiet even if WB is still asserting during reset.
  assign rf_wen   = rst_n && (pipe_wen || !empty);
  assign rf_waddr = pipe_wen ? pipe_waddr : (empty ? '0 : head_rd);
  assign rf_wdata = pipe_wen ? pipe_wdata : (empty ? '0 : head_data);

  always_comb begin
    pending_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (entry_valid[i]) pending_mask[entry_rd[i*5 +: 5]] = 1'b1;
    end
  end

  assign cnt_inc   = (starve_cnt == SW'(STARVE_LIMIT)) ? starve_cnt : starve_cnt + 1'b1;
  assign stall_req = (state == WBARB_FORCE);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = starve_cnt;
    unique case (state)
      WBARB_IDLE: begin
        if (push) begin
          state_nxt = WBARB_WAIT;
          cnt_nxt   = '0;
        end
      end
      WBARB_WAIT, WBARB_FORCE: begin
        if (pop) begin
          cnt_nxt   = '0;
          state_nxt = (push || (count > CW'(1))) ? WBARB_WAIT : WBARB_IDLE;
        end else if (blocked) begin
          cnt_nxt = cnt_inc;
          if ((state == WBARB_WAIT) && (starve_cnt == SW'(STARVE_LIMIT - 1)))
            state_nxt = WBARB_FORCE;
        end
      end
      default: begin
        state_nxt = WBARB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WBARB_IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= cnt_nxt;
    end
  end

endmodule
